// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// holds the word for the decoder. Optional stall counter enabled by FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc,
  input  logic        take_branch,
  input  logic        take_jump
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  input  logic        stall_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic        w_accept;
  logic        w_retire;

  assign w_accept = (r_state == FETCH) && imem_ack;
  assign w_retire = (r_state == HOLD) && instr_ready;

  // NOTE: async active-low reset in the sensitivity list; all state uses <= so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    unique case (r_state)
      IDLE: w_next_state = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) w_next_state = FETCH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_pc4        = r_pc + 32'd4;
  assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // Jump has priority over branch; both are only consumed on retire.
  always_comb begin
    if (take_jump) begin
      w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
    end else if (take_branch) begin
      w_next_pc = w_pc4 + w_branch_off;
    end else begin
      w_next_pc = w_pc4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
    end else if (w_accept) begin
      r_instr <= imem_rdata;
    end else if (w_retire) begin
      r_pc    <= w_next_pc;
      r_instr <= NOP_WORD;
    end
  end

  assign imem_addr = {r_pc[31:2], 2'b00};
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign op        = r_instr[31:26];

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ((r_state == FETCH) && !imem_ack) ||
                   ((r_state == HOLD) && !instr_ready);

  // Saturating count; clear takes priority over a same-cycle stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 32'd0;
    end else if (stall_clr) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: drivers push expected fetch addresses and
// instruction words; a negedge monitor pops and compares them against the DUT.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        take_branch;
  logic        take_jump;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic        stall_clr;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .take_branch (take_branch),
    .take_jump   (take_jump)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .stall_clr   (stall_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference next-PC computed with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                           input bit tb, input bit tj);
    logic [31:0] pc4;
    logic [15:0] imm;
    int          off;
    pc4 = cur_pc + 32'd4;
    imm = ins[15:0];
    off = int'($signed(imm)) * 4;
    if (tj) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (tb) return pc4 + 32'(off);
    return pc4;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int dly);
    int n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    check("fetch_wait", {31'd0, imem_req}, 32'd1);
    if (!imem_req) return;
    repeat (dly) begin imem_ack = 1'b0; step(); end
    imem_ack   = 1'b1;
    imem_rdata = data;
    m_instr    = data;
    exp_instr.push_back(data);
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_retire(input int dly, input bit tb, input bit tj);
    int n = 0;
    while (!instr_valid && n < 20) begin step(); n++; end
    check("retire_wait", {31'd0, instr_valid}, 32'd1);
    if (!instr_valid) return;
    repeat (dly) begin
      imem_ack    = 1'($urandom);
      imem_rdata  = $urandom;
      take_branch = 1'($urandom);
      take_jump   = 1'($urandom);
      instr_ready = 1'b0;
      step();
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    take_branch = tb;
    take_jump   = tj;
    m_pc = ref_next(m_pc, m_instr, tb, tj);
    exp_addr.push_back(m_pc);
    step();
    instr_ready = 1'b0;
    take_branch = 1'($urandom);
    take_jump   = 1'($urandom);
  endtask

  task automatic txn(input logic [31:0] data, input int ad, input int rd, input bit tb, input bit tj);
    do_fetch(data, ad);
    do_retire(rd, tb, tj);
  endtask

  // Monitor: protocol rules plus scoreboard pops on each new request / new instruction.
  logic        p_req, p_ack, p_valid, p_ready;
  logic [31:0] cur_addr, cur_instr, e;
  always @(negedge clk) begin
    if (!reset_n) begin
      p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0;
    end else begin
      check("req_valid_excl", {31'd0, imem_req & instr_valid}, 32'd0);
      if (p_req && p_ack) check("ack_to_valid", {31'd0, instr_valid}, 32'd1);
      if (p_req && !p_ack) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, cur_addr);
      end
      if (p_valid && !p_ready) begin
        check("valid_held", {31'd0, instr_valid}, 32'd1);
        check("instr_stable", instr, cur_instr);
      end
      if (p_valid && p_ready) check("retire_refetch", {31'd0, imem_req}, 32'd1);
      if (!instr_valid) check("instr_nop", instr, NOP_WORD);
      if (imem_req && !p_req) begin
        check("addr_q_nonempty", {31'd0, exp_addr.size() != 0}, 32'd1);
        if (exp_addr.size() != 0) begin
          e = exp_addr.pop_front();
          check("fetch_addr", imem_addr, e);
          check("fetch_pc", pc, e);
        end
        cur_addr = imem_addr;
      end
      if (instr_valid && !p_valid) begin
        check("instr_q_nonempty", {31'd0, exp_instr.size() != 0}, 32'd1);
        if (exp_instr.size() != 0) begin
          e = exp_instr.pop_front();
          check("instr_word", instr, e);
          check("op_field", {26'd0, op}, {26'd0, e[31:26]});
        end
        cur_instr = instr;
      end
      p_req = imem_req; p_ack = imem_ack; p_valid = instr_valid; p_ready = instr_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    take_branch = 1'b0; take_jump = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_op", {26'd0, op}, 32'd0);
    check("rst_instr", instr, NOP_WORD);
    m_pc = RESET_PC;
    exp_addr.push_back(RESET_PC);
    step();
    reset_n = 1'b1;

    // Sequential lw stream: 0, 4, 8, C; then beq at 0x10 taken/not taken.
    repeat (4) txn(32'h8C08_0004, 0, 0, 1'b0, 1'b0);
    txn(32'h1000_FFFE, 0, 0, 1'b1, 1'b0);
    txn(32'h8C08_0004, 0, 0, 1'b0, 1'b0);
    txn(32'h1000_FFFE, 0, 0, 1'b0, 1'b0);

    // Jump wins over branch at 0x14 -> 0x40; stall counter cleared on that retire.
    do_fetch(32'h0800_0010, 0);
`ifdef FETCH_STALL_CNT_EN
    stall_clr = 1'b1;
`endif
    do_retire(0, 1'b1, 1'b1);
`ifdef FETCH_STALL_CNT_EN
    stall_clr = 1'b0;
`endif

    // Backpressure: 3 cycles without ack, 4 cycles without ready.
    txn($urandom, 3, 4, 1'b0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'd7);
`endif

    // Backward branch to 0xFFFF_FFF8, jumps in the top region, then wrap to 0.
    txn(32'h1000_FFEC, 0, 0, 1'b1, 1'b0);
    txn(32'h0800_0010, 0, 0, 1'b0, 1'b1);
    txn(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1);
    txn(32'h8C08_0004, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      txn($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset while a request is outstanding; an ack during the restart cycle is ignored.
    imem_ack = 1'b0;
    step(); step();
    #1 reset_n = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("midrst_pc", pc, RESET_PC);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    exp_addr.delete();
    exp_instr.delete();
    m_pc = RESET_PC;
    exp_addr.push_back(RESET_PC);
    step();
    reset_n = 1'b1;
    step();
    imem_ack = 1'b0;
    check("stale_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("stale_ack_instr", instr, NOP_WORD);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    txn(32'h8C08_0004, 0, 0, 1'b0, 1'b0);
    txn(32'h8C08_0004, 1, 1, 1'b0, 1'b0);

    repeat (3) step();
    check("addr_q_drained", exp_addr.size(), 32'd0);
    check("instr_q_drained", exp_instr.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
